// File: rtl/piezo_seq_pkg.sv
// ---------------------------------------------------------------------------
// piezo_seq_pkg
//   Shared types, constants and helpers for the piezo tune sequencer.
//   - state_t      : sequencer FSM states (IDLE / LOAD / PLAY)
//   - note_t       : one note-table entry {half-period, duration, last flag}
//   - stepSize()   : timer increment per clk for fast-sim or real-time runs
//   - widthOf()    : index width for a count, never narrower than one bit
//   - LEGACY_TUNE  : the six-note charge tune of the fixed-tune driver
// ---------------------------------------------------------------------------
package piezo_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2
    } state_t;

    localparam int NOTE_PER_W = 16;
    localparam int NOTE_DUR_W = 26;
    localparam int FAST_STEP  = 64;

    typedef struct packed {
        logic [NOTE_PER_W-1:0] per;
        logic [NOTE_DUR_W-1:0] dur;
        logic                  last;
    } note_t;

    function automatic int stepSize(input int fastSim);
        return (fastSim != 0) ? FAST_STEP : 1;
    endfunction

    // $clog2 collapses to 0 for a count of 1; ports still need one bit.
    function automatic int widthOf(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

    // Half-periods assume a 50 MHz clock; durations are in timer units.
    localparam int LEGACY_LEN = 6;
    localparam note_t LEGACY_TUNE [LEGACY_LEN] = '{
        '{per: 16'd15944, dur: 26'd8388608,  last: 1'b0},   // G6
        '{per: 16'd11945, dur: 26'd8388608,  last: 1'b0},   // C7
        '{per: 16'd9480,  dur: 26'd8388608,  last: 1'b0},   // E7
        '{per: 16'd7972,  dur: 26'd12582912, last: 1'b0},   // G7
        '{per: 16'd9480,  dur: 26'd4194304,  last: 1'b0},   // E7
        '{per: 16'd7972,  dur: 26'd16777216, last: 1'b1}    // G7
    };

endpackage

// File: rtl/piezo_tone_gen.sv
// ---------------------------------------------------------------------------
// piezo_tone_gen
//   Square-wave generator for one note: a period counter that wraps every
//   i_per enabled cycles and flips the drive phase, plus the complementary
//   output stage for the differential piezo pair.
//   Ports:
//     i_clk, i_rst_n  clock, asynchronous active-low reset
//     i_clr           restart the note: counter and phase back to 0
//     i_en            note is playing (counter runs, outputs may drive)
//     i_per           half-period in clk cycles; 0 means rest
//     o_piezo         drive, high after the first wrap of each note
//     o_piezo_n       complement of o_piezo while sounding, else 0
// ---------------------------------------------------------------------------
module piezo_tone_gen #(
    parameter int PER_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [PER_W-1:0] i_per,
    output logic             o_piezo,
    output logic             o_piezo_n
);

    logic [PER_W-1:0] r_cnt;
    logic             r_phase;
    logic             w_sound;
    logic             w_wrap;

    always_comb begin
        w_sound = i_en && (i_per != '0);
        w_wrap  = (r_cnt == i_per - PER_W'(1));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (i_clr) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (w_sound) begin
            if (w_wrap) begin
                r_cnt   <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_cnt   <= r_cnt + PER_W'(1);
            end
        end
    end

    // Both legs low whenever nothing sounds so the piezo sees no DC.
    always_comb begin
        o_piezo   = w_sound & r_phase;
        o_piezo_n = w_sound & ~r_phase;
    end

endmodule

// File: rtl/piezo_seq.sv
// ---------------------------------------------------------------------------
// piezo_seq
//   Multi-tune piezo sequencer with a run-time writable note table,
//   priority preemption at note boundaries, a shared re-trigger holdoff
//   and rest notes.
//   Ports:
//     i_clk, i_rst_n   clock, asynchronous active-low reset
//     i_req            level tune requests, highest index wins
//     i_wr_en          note-table write strobe
//     i_wr_tune        tune index to write (out-of-range ignored)
//     i_wr_idx         note slot to write
//     i_wr_per         half-period in clk cycles, 0 = rest
//     i_wr_dur         note duration in timer units
//     i_wr_last        slot is the final note of its tune
//     o_piezo          piezo drive
//     o_piezo_n        complementary piezo drive
//     o_busy           high in LOAD and PLAY
//     o_cur_tune       tune playing (holds the last one while idle)
// ---------------------------------------------------------------------------
module piezo_seq
    import piezo_seq_pkg::*;
#(
    parameter  int FAST_SIM   = 1,
    parameter  int NUM_TUNES  = 3,
    parameter  int MAX_NOTES  = 8,
    parameter  int PER_W      = NOTE_PER_W,
    parameter  int DUR_W      = NOTE_DUR_W,
    parameter  int REPEAT_CYC = 150000000,
    localparam int TUNE_W     = widthOf(NUM_TUNES),
    localparam int IDX_W      = widthOf(MAX_NOTES)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [NUM_TUNES-1:0] i_req,
    input  logic              i_wr_en,
    input  logic [TUNE_W-1:0] i_wr_tune,
    input  logic [IDX_W-1:0]  i_wr_idx,
    input  logic [PER_W-1:0]  i_wr_per,
    input  logic [DUR_W-1:0]  i_wr_dur,
    input  logic              i_wr_last,
    output logic              o_piezo,
    output logic              o_piezo_n,
    output logic              o_busy,
    output logic [TUNE_W-1:0] o_cur_tune
);

    localparam int STEP      = stepSize(FAST_SIM);
    // Keep the holdoff counter wide enough to subtract a full step.
    localparam int RPT_W_RAW = widthOf(REPEAT_CYC + 1);
    localparam int RPT_W     = (RPT_W_RAW < 8) ? 8 : RPT_W_RAW;

    localparam logic [DUR_W-1:0] DUR_STEP = DUR_W'(STEP);
    localparam logic [DUR_W-1:0] DUR_MAX  = '1;
    localparam logic [RPT_W-1:0] RPT_STEP = RPT_W'(STEP);
    localparam logic [RPT_W-1:0] RPT_LOAD = RPT_W'(REPEAT_CYC);

    // Same layout as note_t, sized by this instance's field widths.
    typedef struct packed {
        logic [PER_W-1:0] per;
        logic [DUR_W-1:0] dur;
        logic             last;
    } entry_t;

    entry_t            r_table [NUM_TUNES][MAX_NOTES];
    entry_t            r_note;
    state_t            r_state;
    state_t            w_nextState;
    logic [TUNE_W-1:0] r_curTune;
    logic [IDX_W-1:0]  r_idx;
    logic [DUR_W-1:0]  r_durTimer;
    logic [RPT_W-1:0]  r_rptTimer;

    logic [TUNE_W-1:0] w_winner;
    logic              w_reqAny;
    logic              w_wrOk;
    logic              w_start;
    logic              w_noteEnd;
    logic              w_preempt;
    logic              w_tuneDone;
    logic              w_loadRpt;
    logic              w_toneClr;
    logic              w_toneEn;

    // Highest set request bit wins; an empty request reads as tune 0,
    // which can never beat the current tune.
    always_comb begin
        w_reqAny = |i_req;
        w_winner = '0;
        for (int i = 0; i < NUM_TUNES; i++) begin
            if (i_req[i]) begin
                w_winner = TUNE_W'(i);
            end
        end
    end

    always_comb begin
        w_wrOk     = i_wr_en && (int'(i_wr_tune) < NUM_TUNES)
                             && (int'(i_wr_idx) < MAX_NOTES);
        w_preempt  = (w_winner > r_curTune);
        // A strictly higher-priority tune skips the holdoff.
        w_start    = w_reqAny && ((r_rptTimer == '0) || w_preempt);
        w_noteEnd  = (r_durTimer >= r_note.dur);
        w_tuneDone = r_note.last || (r_idx == IDX_W'(MAX_NOTES - 1));
        w_loadRpt  = (r_state == PLAY) && w_noteEnd && !w_preempt && w_tuneDone;
    end

    // Note table: cleared by reset, written one entry per cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int t = 0; t < NUM_TUNES; t++) begin
                for (int n = 0; n < MAX_NOTES; n++) begin
                    r_table[t][n] <= '0;
                end
            end
        end else if (w_wrOk) begin
            r_table[i_wr_tune][i_wr_idx] <= '{per: i_wr_per, dur: i_wr_dur, last: i_wr_last};
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_nextState = LOAD;
                end
            end
            LOAD: begin
                w_nextState = PLAY;
            end
            PLAY: begin
                if (w_noteEnd) begin
                    w_nextState = (!w_preempt && w_tuneDone) ? IDLE : LOAD;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // FSM outputs.
    always_comb begin
        o_busy    = (r_state != IDLE);
        w_toneClr = (r_state == LOAD);
        w_toneEn  = (r_state == PLAY);
    end

    // Tune / note index. The current tune is kept after a tune ends so the
    // holdoff bypass can compare new requests against the last one played.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_curTune <= '0;
            r_idx     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_curTune <= w_winner;
                        r_idx     <= '0;
                    end
                end
                PLAY: begin
                    if (w_noteEnd) begin
                        if (w_preempt) begin
                            r_curTune <= w_winner;
                            r_idx     <= '0;
                        end else if (!w_tuneDone) begin
                            r_idx     <= r_idx + IDX_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // The entry is copied at LOAD, so table writes during a note only
    // affect the next time that slot is loaded.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_note <= '0;
        end else if (r_state == LOAD) begin
            r_note <= r_table[r_curTune][r_idx];
        end
    end

    // Duration timer saturates instead of wrapping so a note with
    // dur near all-ones still ends.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_durTimer <= '0;
        end else if (r_state == LOAD) begin
            r_durTimer <= '0;
        end else if (r_state == PLAY) begin
            if (r_durTimer > DUR_MAX - DUR_STEP) begin
                r_durTimer <= DUR_MAX;
            end else begin
                r_durTimer <= r_durTimer + DUR_STEP;
            end
        end
    end

    // Re-trigger holdoff: reloaded when a tune completes, counts down to 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rptTimer <= '0;
        end else if (w_loadRpt) begin
            r_rptTimer <= RPT_LOAD;
        end else if (r_rptTimer != '0) begin
            r_rptTimer <= (r_rptTimer > RPT_STEP) ? (r_rptTimer - RPT_STEP) : '0;
        end
    end

    piezo_tone_gen #(
        .PER_W (PER_W)
    ) u_toneGen (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clr     (w_toneClr),
        .i_en      (w_toneEn),
        .i_per     (r_note.per),
        .o_piezo   (o_piezo),
        .o_piezo_n (o_piezo_n)
    );

    assign o_cur_tune = r_curTune;

endmodule

// File: tb/tb_piezo_seq.sv
// ---------------------------------------------------------------------------
// tb_piezo_seq
//   Self-checking bench for piezo_seq. Expected per-cycle output samples
//   {busy, cur_tune, piezo, piezo_n} are queued when a request pattern is
//   driven and compared on each falling edge as the DUT produces them.
// ---------------------------------------------------------------------------
module tb_piezo_seq;

    localparam int TIMER_STEP = 64;

    typedef struct packed {
        logic       busy;
        logic [1:0] cur;
        logic       pz;
        logic       pzn;
    } sample_t;

    logic        clk;
    logic        rstN;
    logic [2:0]  req;
    logic        wrEn;
    logic [1:0]  wrTune;
    logic [2:0]  wrIdx;
    logic [15:0] wrPer;
    logic [25:0] wrDur;
    logic        wrLast;
    logic        piezo;
    logic        piezoN;
    logic        busy;
    logic [1:0]  curTune;

    sample_t sbQueue [$];
    int      compareCount  = 0;
    int      mismatchCount = 0;
    int      sampleNum     = 0;

    piezo_seq #(
        .FAST_SIM   (1),
        .NUM_TUNES  (3),
        .MAX_NOTES  (8),
        .PER_W      (16),
        .DUR_W      (26),
        .REPEAT_CYC (1280)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rstN),
        .i_req      (req),
        .i_wr_en    (wrEn),
        .i_wr_tune  (wrTune),
        .i_wr_idx   (wrIdx),
        .i_wr_per   (wrPer),
        .i_wr_dur   (wrDur),
        .i_wr_last  (wrLast),
        .o_piezo    (piezo),
        .o_piezo_n  (piezoN),
        .o_busy     (busy),
        .o_cur_tune (curTune)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Scoreboard consumer: one expected sample per falling edge.
    always @(negedge clk) begin
        sample_t expS;
        if (sbQueue.size() > 0) begin
            expS = sbQueue.pop_front();
            checkOutput($sformatf("busy@%0d", sampleNum),    int'(busy),    int'(expS.busy));
            checkOutput($sformatf("curTune@%0d", sampleNum), int'(curTune), int'(expS.cur));
            checkOutput($sformatf("piezo@%0d", sampleNum),   int'(piezo),   int'(expS.pz));
            checkOutput($sformatf("piezoN@%0d", sampleNum),  int'(piezoN),  int'(expS.pzn));
            sampleNum++;
        end
    end

    task automatic stepCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pushSample(input bit b, input int cur, input bit pz, input bit pzn);
        sample_t s;
        s.busy = b;
        s.cur  = 2'(cur);
        s.pz   = pz;
        s.pzn  = pzn;
        sbQueue.push_back(s);
    endtask

    task automatic pushIdle(input int n, input int cur);
        for (int i = 0; i < n; i++) begin
            pushSample(1'b0, cur, 1'b0, 1'b0);
        end
    endtask

    // One LOAD cycle, then PLAY until the timer (0, 64, 128, ...) reaches dur.
    // Toggles land every per PLAY cycles, the first one driving piezo high.
    task automatic pushNote(input int cur, input int per, input int dur);
        int playCycles;
        playCycles = (dur + TIMER_STEP - 1) / TIMER_STEP + 1;
        pushSample(1'b1, cur, 1'b0, 1'b0);
        for (int j = 0; j < playCycles; j++) begin
            if (per == 0) begin
                pushSample(1'b1, cur, 1'b0, 1'b0);
            end else begin
                bit ph;
                ph = ((j / per) % 2) == 1;
                pushSample(1'b1, cur, ph, !ph);
            end
        end
    endtask

    task automatic applyStimulus(input logic [2:0] reqVal, input int holdCycles);
        req = reqVal;
        stepCycles(holdCycles);
    endtask

    task automatic writeNote(input int tune, input int idx, input int per, input int dur, input bit last);
        wrEn   = 1'b1;
        wrTune = 2'(tune);
        wrIdx  = 3'(idx);
        wrPer  = 16'(per);
        wrDur  = 26'(dur);
        wrLast = last;
        stepCycles(1);
        wrEn   = 1'b0;
    endtask

    task automatic waitDrain();
        int budget;
        budget = 400;
        while (sbQueue.size() != 0 && budget > 0) begin
            stepCycles(1);
            budget--;
        end
        if (sbQueue.size() != 0) begin
            checkOutput("drainTimeout", sbQueue.size(), 0);
            sbQueue.delete();
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rstN   = 1'b1;
        req    = '0;
        wrEn   = 1'b0;
        wrTune = '0;
        wrIdx  = '0;
        wrPer  = '0;
        wrDur  = '0;
        wrLast = 1'b0;
        #1 rstN = 1'b0;
        #2;
        checkOutput("resetPiezo",   int'(piezo),   0);
        checkOutput("resetPiezoN",  int'(piezoN),  0);
        checkOutput("resetBusy",    int'(busy),    0);
        checkOutput("resetCurTune", int'(curTune), 0);
        repeat (3) @(posedge clk);
        #1 rstN = 1'b1;
        stepCycles(1);

        writeNote(0, 0, 4, 640, 1'b0);
        writeNote(0, 1, 6, 640, 1'b1);
        writeNote(1, 0, 2, 192, 1'b1);
        writeNote(2, 0, 2, 128, 1'b0);
        writeNote(2, 1, 0, 640, 1'b0);
        writeNote(2, 2, 1, 64,  1'b1);
        writeNote(3, 0, 9, 64,  1'b1);

        // Two-note tune from a one-cycle request pulse.
        pushIdle(1, 0);
        pushNote(0, 4, 640);
        pushNote(0, 6, 640);
        pushIdle(3, 0);
        applyStimulus(3'b001, 1);
        applyStimulus(3'b000, 0);
        waitDrain();
        pushIdle(25, 0);
        waitDrain();

        // Held request: holdoff of 1280/64 = 20 steps, then replay.
        pushIdle(1, 0);
        pushNote(0, 4, 640);
        pushNote(0, 6, 640);
        pushIdle(21, 0);
        applyStimulus(3'b001, 0);
        waitDrain();
        pushNote(0, 4, 640);
        pushNote(0, 6, 640);
        pushIdle(2, 0);
        applyStimulus(3'b000, 0);
        waitDrain();
        pushIdle(25, 0);
        waitDrain();

        // Preemption at a note boundary, rest note, ignored lower request,
        // then the lower tune waits out the holdoff.
        pushIdle(1, 0);
        pushNote(0, 4, 640);
        pushNote(2, 2, 128);
        pushNote(2, 0, 640);
        pushNote(2, 1, 64);
        pushIdle(21, 2);
        pushNote(1, 2, 192);
        pushIdle(3, 1);
        applyStimulus(3'b001, 4);
        applyStimulus(3'b101, 11);
        applyStimulus(3'b010, 40);
        applyStimulus(3'b000, 0);
        waitDrain();
        pushIdle(25, 1);
        waitDrain();

        // Reset in the middle of a sounding note.
        pushIdle(1, 1);
        pushSample(1'b1, 1, 1'b0, 1'b0);
        pushSample(1'b1, 1, 1'b0, 1'b1);
        pushSample(1'b1, 1, 1'b0, 1'b1);
        pushSample(1'b1, 1, 1'b1, 1'b0);
        applyStimulus(3'b010, 0);
        waitDrain();
        rstN = 1'b0;
        req  = '0;
        #1;
        checkOutput("midResetPiezo",   int'(piezo),   0);
        checkOutput("midResetPiezoN",  int'(piezoN),  0);
        checkOutput("midResetBusy",    int'(busy),    0);
        checkOutput("midResetCurTune", int'(curTune), 0);
        stepCycles(2);
        rstN = 1'b1;
        stepCycles(1);

        // Cleared table: eight silent zero-duration notes, 2 cycles each.
        pushIdle(1, 0);
        for (int n = 0; n < 8; n++) begin
            pushNote(0, 0, 0);
        end
        pushIdle(2, 0);
        applyStimulus(3'b001, 1);
        applyStimulus(3'b000, 0);
        waitDrain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/piezo_seq.md
Name: piezo_seq

Overview:
- Parametrised successor to the fixed-tune piezo driver.
- Plays one of NUM_TUNES tunes from a run-time-writable note table.
- Drives a complementary differential piezo pair.
- Sits beside the Segway monitor; request lines come from the steering, over-speed and battery logic. Adds priority preemption, a shared re-trigger (repeat) holdoff and rest notes.

Parameters:
- FAST_SIM, 1, duration/repeat timers advance by 64 per clk when 1, by 1 when 0.
- NUM_TUNES, 3, number of tunes; request index NUM_TUNES-1 has highest priority.
- MAX_NOTES, 8, note slots per tune.
- PER_W, 16, half-period field width, in clk cycles.
- DUR_W, 26, note duration field width, in timer units.
- REPEAT_CYC, 150000000, holdoff after a tune ends, in timer units.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req  in  NUM_TUNES  level tune requests
- wr_en  in  1  note-table write strobe
- wr_tune  in  clog2(NUM_TUNES)  write tune index
- wr_idx  in  clog2(MAX_NOTES)  write note slot
- wr_per  in  PER_W  half-period; 0 = rest
- wr_dur  in  DUR_W  note duration
- wr_last  in  1  marks the final note of the tune
- piezo  out  1  piezo drive
- piezo_n  out  1  complementary drive
- busy  out  1  a tune is playing
- cur_tune  out  clog2(NUM_TUNES)  index of the tune playing

Behaviour:
- Reset:
  - piezo=0, piezo_n=0, busy=0, cur_tune=0.
  - Table cleared to all zero (per=0, dur=0, last=0).
  - Repeat timer = 0 (expired). State IDLE.
- Table:
  - Synchronous write on wr_en, visible the next cycle.
  - A write to the playing tune takes effect at the next LOAD of that slot.
  - Out-of-range wr_tune is ignored.
- Winner: highest set bit of req.
- States and transitions:
  - IDLE: when req!=0 and (repeat timer expired or winner > last-played tune), latch winner into cur_tune, note index 0, go to LOAD. A higher-priority tune bypasses the holdoff.
  - LOAD (1 cycle): register the {per, dur, last} entry. Clear the duration timer, period counter and toggle phase. Go to PLAY.
  - PLAY:
    - Duration timer += step.
    - Period counter counts 0..per-1; on reaching per-1 it wraps and piezo toggles.
    - When duration timer >= dur, the note ends:
      - If winner > cur_tune: preempt, cur_tune=winner, index 0, go to LOAD.
      - Else if last=1 or index=MAX_NOTES-1: load repeat timer with REPEAT_CYC, go to IDLE.
      - Else index+1, go to LOAD.
- Step and timers:
  - Step = 64 if FAST_SIM else 1.
  - Duration timer saturates at all-ones and never wraps.
  - Repeat timer decrements by step while nonzero and clamps at 0; it does not underflow.
- Notes:
  - dur=0 gives a 2-cycle note (LOAD + one PLAY cycle).
  - per=0 is a rest: piezo and piezo_n are held 0.
- Outputs:
  - While a tone sounds, piezo_n = ~piezo every cycle.
  - In IDLE, LOAD or a rest, both outputs are 0.
  - Each note starts with piezo=1 on the first toggle.
  - busy=1 in LOAD and PLAY.
- Requests:
  - Dropping req mid-tune does not abort it; the tune runs to completion.
  - Preemption is evaluated only at note boundaries.
  - A request equal to or lower than cur_tune during PLAY is ignored.
- Reset asserted mid-note: immediate return to the reset state, outputs 0, table cleared.

Decomposition:
- Package piezo_seq_pkg:
  - state enum {IDLE, LOAD, PLAY}
  - note_t struct {per, dur, last}
  - function fast-sim step
  - default note constants for the legacy six-note tune (G6 C7 E7 G7 E7 G7)
- Sub-module piezo_tone_gen: period counter plus complementary output stage, with inputs clr, per and en.

Test Plan:
- Write tune0 = {per 4 dur 640, per 6 dur 640 last}, FAST_SIM=1, pulse req[0] -> busy one cycle later; piezo toggles every 4 clk for 11 cycles, then every 6 clk; busy drops after about 24 cycles; piezo_n == ~piezo throughout.
- Hold req[0] after completion with REPEAT_CYC=1280 -> no restart for 20 cycles; LOAD occurs on the first cycle after expiry.
- Tune0 playing, assert req[2] mid-note -> tune0's note finishes; the next LOAD uses tune2 slot 0 and cur_tune=2.
- Tune2 playing, assert req[1] -> ignored; tune2 completes, then tune1 waits for the holdoff.
- Slot with per=0 dur=640 -> piezo=piezo_n=0 for the note while busy=1.
- Assert rst_n low mid-PLAY -> outputs 0 asynchronously; after release a req produces no tone because the table is cleared (per=0 on every slot).
